// File: rtl/bank_act_sched_pkg.sv
// Shared types and default timing for the per-bank activate/precharge scheduler.
package bank_act_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACT_WAIT,
        ST_HIT,
        ST_DEFER1,
        ST_DEFER2,
        ST_ACT_CMD,
        ST_PRE_WAIT_DATA,
        ST_PRE_WAIT,
        ST_PRE_CMD,
        ST_PRE_RP,
        ST_PALL_WAIT_DATA,
        ST_PALL_WAIT,
        ST_PALL_CMD,
        ST_PALL_RP
    } bank_act_state_t;

    localparam int unsigned DEF_NUM_BANKS = 16;
    localparam int unsigned DEF_RA_WIDTH  = 15;
    localparam int unsigned DEF_ACT_DELAY = 2;
    localparam int unsigned DEF_T_RP      = 11;
    localparam int unsigned DEF_T_RTP     = 6;
    localparam int unsigned DEF_T_WR      = 12;
    localparam int unsigned DEF_WL        = 9;
    localparam int unsigned DEF_CNT_W     = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bank_act_sched_open_row_table.sv
// Open-row table: one {valid, row} entry per bank with combinational lookup.
module open_row_table #(
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned BA_W      = $clog2(NUM_BANKS),
    parameter int unsigned RA_WIDTH  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BA_W-1:0]     lookup_bank,
    output logic                lookup_valid,
    output logic [RA_WIDTH-1:0] lookup_row,
    input  logic                set_en,
    input  logic [BA_W-1:0]     set_bank,
    input  logic [RA_WIDTH-1:0] set_row,
    input  logic                clr_en,
    input  logic [BA_W-1:0]     clr_bank,
    input  logic                clr_all
);

    logic [NUM_BANKS-1:0] r_valid;
    logic [RA_WIDTH-1:0]  r_row [NUM_BANKS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (clr_all) begin
            r_valid <= '0;
        end else begin
            if (clr_en) r_valid[clr_bank] <= 1'b0;
            if (set_en) r_valid[set_bank] <= 1'b1;
        end
    end

    // Row storage needs no reset: it is only meaningful while valid is set.
    always_ff @(posedge clk) begin
        if (set_en) r_row[set_bank] <= set_row;
    end

    assign lookup_valid = r_valid[lookup_bank];
    assign lookup_row   = r_row[lookup_bank];

endmodule

// File: rtl/bank_act_sched.sv
// Per-bank ACT/PRE scheduler: classifies requests against the open-row table and spaces commands.
module bank_act_sched
    import bank_act_sched_pkg::*;
#(
    parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
    parameter int unsigned BA_W      = $clog2(NUM_BANKS),
    parameter int unsigned RA_WIDTH  = DEF_RA_WIDTH,
    parameter int unsigned ACT_DELAY = DEF_ACT_DELAY,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned T_RTP     = DEF_T_RTP,
    parameter int unsigned T_WR      = DEF_T_WR,
    parameter int unsigned WL        = DEF_WL,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                clock_t,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BA_W-1:0]     req_bank,
    input  logic [RA_WIDTH-1:0] req_row,
    input  logic                req_rw,
    input  logic                cas_busy,
    input  logic                cas_idle,
    input  logic                last_cas_rw,
    input  logic                close_all,
    output logic                cas_go,
    output logic                act_valid,
    output logic                pre_valid,
    output logic                pre_all,
    output logic [BA_W-1:0]     cmd_bank,
    output logic [RA_WIDTH-1:0] cmd_row,
    output logic                cmd_rw,
    output logic                close_done,
    output logic                idle
);

    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RP_FULL   = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] EXTRA_RD  = CNT_W'(T_RTP);
    localparam logic [CNT_W-1:0] EXTRA_WR  = CNT_W'(WL + 4 + T_WR);

    bank_act_state_t       r_state, w_next;
    logic [CNT_W-1:0]      r_cnt, r_extra;
    logic [BA_W-1:0]       r_bank;
    logic [RA_WIDTH-1:0]   r_row;
    logic                  r_rw;
    logic                  w_lk_valid, w_hit;
    logic [RA_WIDTH-1:0]   w_lk_row;
    logic                  w_cas_go, w_act, w_pre, w_pre_all, w_done;

    open_row_table #(
        .NUM_BANKS (NUM_BANKS),
        .BA_W      (BA_W),
        .RA_WIDTH  (RA_WIDTH)
    ) u_table (
        .clk          (clock_t),
        .rst_n        (reset_n),
        .lookup_bank  (r_bank),
        .lookup_valid (w_lk_valid),
        .lookup_row   (w_lk_row),
        .set_en       (w_act),
        .set_bank     (r_bank),
        .set_row      (r_row),
        .clr_en       (w_pre && !w_pre_all),
        .clr_bank     (r_bank),
        .clr_all      (w_pre_all)
    );

    assign w_hit = w_lk_valid && (w_lk_row == r_row);

    always_comb begin
        w_next    = r_state;
        w_cas_go  = 1'b0;
        w_act     = 1'b0;
        w_pre     = 1'b0;
        w_pre_all = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (close_all)      w_next = ST_PALL_WAIT_DATA;
                else if (req_valid) w_next = ST_ACT_WAIT;
            end
            ST_ACT_WAIT: begin
                if (r_cnt == ACT_LAST) begin
                    if (w_hit)            w_next = ST_HIT;
                    else if (!w_lk_valid) w_next = cas_busy ? ST_DEFER1 : ST_ACT_CMD;
                    else                  w_next = ST_PRE_WAIT_DATA;
                end
            end
            ST_HIT: begin
                w_cas_go = 1'b1;
                w_next   = ST_IDLE;
            end
            ST_DEFER1: w_next = ST_DEFER2;
            ST_DEFER2: w_next = ST_ACT_CMD;
            ST_ACT_CMD: begin
                w_act  = 1'b1;
                w_next = ST_IDLE;
            end
            ST_PRE_WAIT_DATA: if (cas_idle) w_next = ST_PRE_WAIT;
            ST_PRE_WAIT:      if (r_cnt == r_extra) w_next = ST_PRE_CMD;
            ST_PRE_CMD: begin
                w_pre  = 1'b1;
                w_next = ST_PRE_RP;
            end
            ST_PRE_RP:         if (r_cnt == RP_LAST) w_next = ST_ACT_CMD;
            ST_PALL_WAIT_DATA: if (cas_idle) w_next = ST_PALL_WAIT;
            ST_PALL_WAIT:      if (r_cnt == r_extra) w_next = ST_PALL_CMD;
            ST_PALL_CMD: begin
                w_pre     = 1'b1;
                w_pre_all = 1'b1;
                w_next    = ST_PALL_RP;
            end
            // close_done fires on the extra cycle so it lands T_RP+1 after the PRE-all
            ST_PALL_RP: begin
                if (r_cnt == RP_FULL) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_extra <= '0;
            r_bank  <= '0;
            r_row   <= '0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == ST_IDLE && !close_all && req_valid) begin
                r_bank <= req_bank;
                r_row  <= req_row;
                r_rw   <= req_rw;
            end
            if ((r_state == ST_PRE_WAIT_DATA || r_state == ST_PALL_WAIT_DATA) && cas_idle)
                r_extra <= (last_cas_rw == RW_READ) ? EXTRA_RD : EXTRA_WR;
        end
    end

    assign idle       = reset_n && (r_state == ST_IDLE);
    assign req_ready  = idle;
    assign cas_go     = reset_n && w_cas_go;
    assign act_valid  = reset_n && w_act;
    assign pre_valid  = reset_n && w_pre;
    assign pre_all    = reset_n && w_pre_all;
    assign close_done = reset_n && w_done;
    assign cmd_bank   = reset_n ? r_bank : '0;
    assign cmd_row    = reset_n ? r_row  : '0;
    assign cmd_rw     = reset_n && r_rw;

endmodule

// File: tb/tb_bank_act_sched.sv
// Scoreboard bench for bank_act_sched: directed requests push expected pulses, a negedge monitor checks them.
module tb_bank_act_sched;

    localparam int BA_W = 4;
    localparam int RA_W = 15;
    localparam int EXTRA_WR = 9 + 4 + 12;
    localparam int EXTRA_RD = 6;
    localparam int TRP = 11;

    localparam int K_CAS  = 0;
    localparam int K_ACT  = 1;
    localparam int K_PRE  = 2;
    localparam int K_PALL = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [3:0]  bank;
        logic [14:0] row;
        logic        rw;
        bit          chk_cmd;
    } exp_t;

    logic            clock_t = 1'b0;
    logic            reset_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [BA_W-1:0] req_bank = '0;
    logic [RA_W-1:0] req_row = '0;
    logic            req_rw = 1'b0;
    logic            cas_busy = 1'b0;
    logic            cas_idle = 1'b1;
    logic            last_cas_rw = 1'b1;
    logic            close_all = 1'b0;
    logic            cas_go, act_valid, pre_valid, pre_all, cmd_rw, close_done, idle;
    logic [BA_W-1:0] cmd_bank;
    logic [RA_W-1:0] cmd_row;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    bank_act_sched dut (
        .clock_t     (clock_t),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bank    (req_bank),
        .req_row     (req_row),
        .req_rw      (req_rw),
        .cas_busy    (cas_busy),
        .cas_idle    (cas_idle),
        .last_cas_rw (last_cas_rw),
        .close_all   (close_all),
        .cas_go      (cas_go),
        .act_valid   (act_valid),
        .pre_valid   (pre_valid),
        .pre_all     (pre_all),
        .cmd_bank    (cmd_bank),
        .cmd_row     (cmd_row),
        .cmd_rw      (cmd_rw),
        .close_done  (close_done),
        .idle        (idle)
    );

    always #5 clock_t = ~clock_t;
    always @(posedge clock_t) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clock_t) begin
        int   np;
        int   kind;
        exp_t e;
        np = int'(cas_go) + int'(act_valid) + int'(pre_valid) + int'(close_done);
        if (np > 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL multi_pulse cyc=%0d cas=%b act=%b pre=%b done=%b required at most one",
                     cyc, cas_go, act_valid, pre_valid, close_done);
        end else if (np == 1) begin
            if (cas_go)                     kind = K_CAS;
            else if (act_valid)             kind = K_ACT;
            else if (pre_valid && pre_all)  kind = K_PALL;
            else if (pre_valid)             kind = K_PRE;
            else                            kind = K_DONE;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d kind=%0d required none", cyc, kind);
            end else begin
                e = q.pop_front();
                if (kind != e.kind || cyc != e.cyc ||
                    (e.chk_cmd && (cmd_bank != e.bank || cmd_row != e.row || cmd_rw != e.rw)) ||
                    (e.kind == K_PRE && cmd_bank != e.bank)) begin
                    n_fail++;
                    $display("FAIL pulse kind=%0d cyc=%0d bank=%0d row=%h rw=%b required kind=%0d cyc=%0d bank=%0d row=%h rw=%b",
                             kind, cyc, cmd_bank, cmd_row, cmd_rw, e.kind, e.cyc, e.bank, e.row, e.rw);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_pulse(input int kind, input int at, input logic [3:0] bank,
                                input logic [14:0] row, input logic rw, input bit chk);
        exp_t e;
        e.kind = kind; e.cyc = at; e.bank = bank; e.row = row; e.rw = rw; e.chk_cmd = chk;
        q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clock_t);
        while (!req_ready && n < 200) begin
            @(negedge clock_t);
            n++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout got=0 required=1", name);
        end
    endtask

    task automatic do_req(input logic [3:0] bank, input logic [14:0] row, input logic rw, output int acc);
        wait_ready("req");
        req_valid = 1'b1; req_bank = bank; req_row = row; req_rw = rw;
        @(posedge clock_t);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clock_t);
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain_timeout pending=%0d required=0", name, q.size());
            q.delete();
        end
        repeat (2) @(negedge clock_t);
    endtask

    initial begin
        int a;
        int c;
        repeat (3) @(negedge clock_t);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_idle", 32'(idle), 0);
        check("rst_cmd_bank", 32'(cmd_bank), 0);
        check("rst_cmd_row", 32'(cmd_row), 0);
        reset_n = 1'b1;
        @(posedge clock_t); #1;
        check("post_rst_ready", 32'(req_ready), 1);
        check("post_rst_idle", 32'(idle), 1);

        // Empty bank -> ACT two cycles after accept
        do_req(4'd3, 15'h01A2, 1'b0, a);
        expect_pulse(K_ACT, a + 2, 4'd3, 15'h01A2, 1'b0, 1);
        drain("t1");

        // Same row -> hit
        do_req(4'd3, 15'h01A2, 1'b1, a);
        expect_pulse(K_CAS, a + 2, 4'd3, 15'h01A2, 1'b1, 1);
        drain("t2");

        // Miss after a write -> PRE after write recovery, ACT T_RP+1 later
        last_cas_rw = 1'b0;
        do_req(4'd3, 15'h0055, 1'b1, a);
        expect_pulse(K_PRE, a + 4 + EXTRA_WR, 4'd3, 15'h0, 1'b0, 0);
        expect_pulse(K_ACT, a + 4 + EXTRA_WR + TRP + 1, 4'd3, 15'h0055, 1'b1, 1);
        drain("t3");

        // Empty bank with CAS collision -> ACT deferred two cycles
        cas_busy = 1'b1;
        do_req(4'd5, 15'h0123, 1'b0, a);
        expect_pulse(K_ACT, a + 4, 4'd5, 15'h0123, 1'b0, 1);
        drain("t4");
        cas_busy = 1'b0;

        // Open banks 1 and 2, then precharge-all after a read
        do_req(4'd1, 15'h00AB, 1'b1, a);
        expect_pulse(K_ACT, a + 2, 4'd1, 15'h00AB, 1'b1, 1);
        drain("t5a");
        do_req(4'd2, 15'h00CD, 1'b0, a);
        expect_pulse(K_ACT, a + 2, 4'd2, 15'h00CD, 1'b0, 1);
        drain("t5b");
        last_cas_rw = 1'b1;
        wait_ready("pall");
        close_all = 1'b1;
        @(posedge clock_t); #1;
        c = cyc;
        close_all = 1'b0;
        expect_pulse(K_PALL, c + 2 + EXTRA_RD, 4'd0, 15'h0, 1'b0, 0);
        expect_pulse(K_DONE, c + 2 + EXTRA_RD + TRP + 1, 4'd0, 15'h0, 1'b0, 0);
        drain("t5c");
        do_req(4'd1, 15'h00AB, 1'b0, a);
        expect_pulse(K_ACT, a + 2, 4'd1, 15'h00AB, 1'b0, 1);
        drain("t5d");

        // Miss on bank 1, reset lands in PRE_RP: the pending ACT must never appear
        do_req(4'd1, 15'h0111, 1'b1, a);
        expect_pulse(K_PRE, a + 4 + EXTRA_RD, 4'd1, 15'h0, 1'b0, 0);
        while (cyc < a + 4 + EXTRA_RD + 5) @(negedge clock_t);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 0);
        check("midrst_act", 32'(act_valid), 0);
        repeat (3) @(negedge clock_t);
        reset_n = 1'b1;
        @(posedge clock_t); #1;
        check("midrst_release_ready", 32'(req_ready), 1);
        repeat (TRP + 10) @(negedge clock_t);
        check("midrst_queue_empty", 32'(q.size()), 0);
        q.delete();
        do_req(4'd1, 15'h0111, 1'b1, a);
        expect_pulse(K_ACT, a + 2, 4'd1, 15'h0111, 1'b1, 1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
